// File: rtl/nand_phy_dq_rd_calib.sv
// Per-lane DQ read-capture calibration: counts 4-phase sample errors against a training
// pattern and picks clk0/clk180 capture per lane. Optional readback: NAND_PHY_RD_CALIB_ERRCNT_EN.
module nand_phy_dq_rd_calib #(
  parameter int          DQ_WIDTH    = 8,
  parameter int          NUM_SAMPLES = 64,
  parameter int unsigned ERR_THRESH  = 0,
  parameter int          CNT_W       = $clog2(NUM_SAMPLES + 1),
  localparam int         RB_W        = (DQ_WIDTH > 1) ? $clog2(DQ_WIDTH) : 1
) (
  input  logic                clk0,
  input  logic                rst0_n,
  input  logic                calib_start,
  input  logic                calib_abort,
  input  logic                samp_valid,
  input  logic [DQ_WIDTH-1:0] samp_rise_0,
  input  logic [DQ_WIDTH-1:0] samp_rise_90,
  input  logic [DQ_WIDTH-1:0] samp_rise_180,
  input  logic [DQ_WIDTH-1:0] samp_rise_270,
  input  logic [DQ_WIDTH-1:0] exp_rise,
  output logic                calib_busy,
  output logic                calib_done,
  output logic [DQ_WIDTH-1:0] clk0_sel,
  output logic [DQ_WIDTH-1:0] calib_fail,
  input  logic [RB_W-1:0]     rb_lane,
  input  logic [1:0]          rb_phase,
  output logic [CNT_W-1:0]    rb_err_cnt
);

  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_COLLECT, ST_DECIDE, ST_DONE
  } state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     samp_cnt_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 publish_reg;
  logic [DQ_WIDTH-1:0]  sel_reg;
  logic [DQ_WIDTH-1:0]  fail_reg;
  logic [DQ_WIDTH-1:0]  dec_sel;
  logic [DQ_WIDTH-1:0]  dec_fail;
  logic [3:0][DQ_WIDTH-1:0] samp_ph;
  logic                 cnt_clear;
  logic                 cnt_accept;

  assign samp_ph    = {samp_rise_270, samp_rise_180, samp_rise_90, samp_rise_0};
  assign cnt_clear  = (state_reg == ST_CLEAR);
  assign cnt_accept = (state_reg == ST_COLLECT) && samp_valid && !calib_abort;

`ifdef NAND_PHY_RD_CALIB_ERRCNT_EN
  logic [3:0][CNT_W-1:0] err_cnt [DQ_WIDTH];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DQ_WIDTH; gi++) begin : g_lane
      // index 0..3 = phase 0/90/180/270
      logic [3:0][CNT_W-1:0] cnt_reg;
      logic [SW-1:0]         score0;
      logic [SW-1:0]         score180;
      logic [CNT_W-1:0]      chosen_err;

      always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
          cnt_reg <= '0;
        end else if (cnt_clear) begin
          cnt_reg <= '0;
        end else if (cnt_accept) begin
          for (int p = 0; p < 4; p++) begin
            cnt_reg[p] <= cnt_reg[p] + CNT_W'(samp_ph[p][gi] ^ exp_rise[gi]);
          end
        end
      end

      // Each score sums the chosen phase plus its two quadrature neighbours.
      assign score0   = SW'(cnt_reg[3]) + SW'(cnt_reg[0]) + SW'(cnt_reg[1]);
      assign score180 = SW'(cnt_reg[1]) + SW'(cnt_reg[2]) + SW'(cnt_reg[3]);
      assign dec_sel[gi]  = (score0 <= score180);
      assign chosen_err   = dec_sel[gi] ? cnt_reg[0] : cnt_reg[2];
      assign dec_fail[gi] = (32'(chosen_err) > ERR_THRESH);

`ifdef NAND_PHY_RD_CALIB_ERRCNT_EN
      assign err_cnt[gi] = cnt_reg;
`endif
    end
  endgenerate

  // Results are published one cycle after DECIDE, together with calib_done.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_reg    <= ST_IDLE;
      samp_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      publish_reg  <= 1'b0;
      sel_reg      <= '1;
      fail_reg     <= '0;
    end else begin
      publish_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (calib_start) begin
            state_reg <= calib_abort ? ST_IDLE : ST_CLEAR;
            done_reg  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          samp_cnt_reg <= '0;
          if (calib_abort) begin
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_COLLECT;
            busy_reg  <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (calib_abort) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (samp_valid) begin
            samp_cnt_reg <= samp_cnt_reg + CNT_W'(1);
            if (samp_cnt_reg == LAST_CNT) begin
              state_reg <= ST_DECIDE;
            end
          end
        end
        ST_DECIDE: begin
          state_reg   <= ST_DONE;
          publish_reg <= 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (publish_reg) begin
        sel_reg  <= dec_sel;
        fail_reg <= dec_fail;
        busy_reg <= 1'b0;
        done_reg <= !calib_start;
      end
    end
  end

  assign calib_busy = busy_reg;
  assign calib_done = done_reg;
  assign clk0_sel   = sel_reg;
  assign calib_fail = fail_reg;

`ifdef NAND_PHY_RD_CALIB_ERRCNT_EN
  logic [CNT_W-1:0] rb_cnt_reg;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rb_cnt_reg <= '0;
    end else if (32'(rb_lane) >= DQ_WIDTH) begin
      rb_cnt_reg <= '0;
    end else begin
      rb_cnt_reg <= err_cnt[rb_lane][rb_phase];
    end
  end

  assign rb_err_cnt = rb_cnt_reg;
`else
  logic rb_unused;
  assign rb_unused  = ^{rb_lane, rb_phase};
  assign rb_err_cnt = '0;
`endif

endmodule
